// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_write_arbiter: round-robin share of the single register-file write
// port between core write-back and load return. Revision 1.0
// ============================================================================
module regfile_write_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_rd,
  input  logic [WIDTH-1:0]      req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_rd,
  input  logic [WIDTH-1:0]      req1_data,
  output logic                  req1_ready,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] Rd,
  output logic [WIDTH-1:0]      WriteData,
  input  logic [ADDR_WIDTH-1:0] query_rs1,
  input  logic [ADDR_WIDTH-1:0] query_rs2,
  output logic                  rs1_pending,
  output logic                  rs2_pending
);

  logic                  last;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_rd;
  logic [WIDTH-1:0]      out_data;
  logic                  grant0;
  logic                  grant1;
  logic [ADDR_WIDTH-1:0] win_rd;
  logic [WIDTH-1:0]      win_data;

  // last == 1 means requester 1 won most recently, so requester 0 wins a tie
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = last;
        grant1 = ~last;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign win_rd     = grant1 ? req1_rd   : req0_rd;
  assign win_data   = grant1 ? req1_data : req0_data;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_rd    <= '0;
      out_data  <= '0;
      last      <= 1'b1;
    end else begin
      out_valid <= 1'b0;
      if (grant0 || grant1) begin
        last <= grant1;
        if (win_rd != '0) begin
          out_valid <= 1'b1;
          out_rd    <= win_rd;
          out_data  <= win_data;
        end
      end
    end
  end

  // Gating with rst keeps an uncommitted write from landing on the reset edge
  assign RegWrite  = out_valid & ~rst;
  assign Rd        = out_rd;
  assign WriteData = out_data;

  assign rs1_pending = (query_rs1 != '0) &&
                       ((out_valid  && (out_rd  == query_rs1)) ||
                        (req0_valid && (req0_rd == query_rs1)) ||
                        (req1_valid && (req1_rd == query_rs1)));

  assign rs2_pending = (query_rs2 != '0) &&
                       ((out_valid  && (out_rd  == query_rs2)) ||
                        (req0_valid && (req0_rd == query_rs2)) ||
                        (req1_valid && (req1_rd == query_rs2)));

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_write_arbiter: directed + randomized bench with a behavioural
// model of the shared write port. Revision 1.0
// ============================================================================
module tb_regfile_write_arbiter;
  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_rd, req1_rd;
  logic [W-1:0]  req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          RegWrite;
  logic [AW-1:0] Rd;
  logic [W-1:0]  WriteData;
  logic [AW-1:0] query_rs1, query_rs2;
  logic          rs1_pending, rs2_pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .RegWrite(RegWrite), .Rd(Rd), .WriteData(WriteData),
    .query_rs1(query_rs1), .query_rs2(query_rs2),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending)
  );

  // Behavioural model: who won last, and the write currently on the port
  int            m_last;
  bit            m_wr;
  logic [AW-1:0] m_rd;
  logic [W-1:0]  m_data;
  logic [W-1:0]  m_rf [32];
  logic [W-1:0]  d_rf [32];

  // Register file as seen by the DUT's port
  always @(posedge clk) if (RegWrite) d_rf[Rd] <= WriteData;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner();
    if (rst) return -1;
    if (req0_valid && req1_valid) return 1 - m_last;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  function automatic bit pend(input logic [AW-1:0] q);
    if (q == 0) return 1'b0;
    return (m_wr && m_rd == q) || (req0_valid && req0_rd == q) || (req1_valid && req1_rd == q);
  endfunction

  // Called at a negedge with inputs set; compares, crosses one posedge,
  // advances the model and returns at the following negedge.
  task automatic tick(output int g);
    logic [AW-1:0] rd;
    #2;
    g = winner();
    chk("req0_ready", req0_ready, g == 0);
    chk("req1_ready", req1_ready, g == 1);
    chk("RegWrite", RegWrite, m_wr && !rst);
    chk("Rd", Rd, m_rd);
    chk("WriteData", WriteData, m_data);
    chk("rs1_pending", rs1_pending, pend(query_rs1));
    chk("rs2_pending", rs2_pending, pend(query_rs2));
    @(posedge clk);
    if (m_wr && !rst) m_rf[m_rd] = m_data;
    if (rst) begin
      m_wr = 0; m_rd = '0; m_data = '0; m_last = 1;
    end else begin
      m_wr = 0;
      if (g >= 0) begin
        m_last = g;
        rd = (g == 1) ? req1_rd : req0_rd;
        if (rd != 0) begin
          m_wr   = 1;
          m_rd   = rd;
          m_data = (g == 1) ? req1_data : req0_data;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_rd = '0; req0_data = '0;
    req1_valid = 0; req1_rd = '0; req1_data = '0;
  endtask

  initial begin
    int g;
    int seq_g [4];
    logic [AW-1:0] seq_rd [4];
    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; d_rf[i] = '0; end
    m_last = 1; m_wr = 0; m_rd = '0; m_data = '0;
    rst = 1; idle_inputs(); query_rs1 = '0; query_rs2 = '0;
    @(negedge clk);

    // Reset held with a pending request
    req0_valid = 1; req0_rd = 5; req0_data = 32'hAAAA_0000;
    #1 chk("rst_ready0_lit", req0_ready, 0);
    chk("rst_regwrite_lit", RegWrite, 0);
    tick(g); tick(g);
    rst = 0;
    #1 chk("post_rst_ready0_lit", req0_ready, 1);
    tick(g);
    req0_valid = 0;
    #1 chk("post_rst_regwrite_lit", RegWrite, 1);
    chk("post_rst_rd_lit", Rd, 5);
    chk("post_rst_data_lit", WriteData, 32'hAAAA_0000);
    chk("model_pin_wr", m_wr, 1);
    tick(g);

    // Contention, from a fresh reset so the first tie goes to req0
    rst = 1; tick(g); rst = 0;
    chk("model_pin_last", m_last, 1);
    req0_valid = 1; req0_rd = 3; req0_data = 32'h11;
    req1_valid = 1; req1_rd = 4; req1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      tick(g);
      seq_g[i] = g;
      seq_rd[i] = Rd;
    end
    idle_inputs();
    chk("cont_grant0_lit", seq_g[0], 0);
    chk("cont_grant1_lit", seq_g[1], 1);
    chk("cont_grant2_lit", seq_g[2], 0);
    chk("cont_grant3_lit", seq_g[3], 1);
    chk("cont_rd0_lit", seq_rd[0], 3);
    chk("cont_rd1_lit", seq_rd[1], 4);
    chk("cont_rd2_lit", seq_rd[2], 3);
    chk("cont_rd3_lit", seq_rd[3], 4);
    tick(g);

    // x0 write is accepted and dropped
    req1_valid = 1; req1_rd = 0; req1_data = 32'hDEAD_BEEF;
    #1 chk("x0_ready1_lit", req1_ready, 1);
    tick(g);
    req1_valid = 0;
    req0_valid = 1; req0_rd = 1; req0_data = 32'h101;
    req1_valid = 1; req1_rd = 2; req1_data = 32'h202;
    #1 chk("x0_regwrite_lit", RegWrite, 0);
    chk("x0_tie_ready0_lit", req0_ready, 1);
    tick(g);
    req0_valid = 0;
    tick(g);
    idle_inputs();
    tick(g); tick(g);

    // Pending flag lifetime
    query_rs1 = 7; query_rs2 = 0;
    req0_valid = 1; req0_rd = 7; req0_data = 32'h77;
    #1 chk("pend_grant_cycle_lit", rs1_pending, 1);
    tick(g);
    req0_valid = 0;
    #1 chk("pend_write_cycle_lit", rs1_pending, 1);
    chk("pend_rs2_zero_lit", rs2_pending, 0);
    tick(g);
    #1 chk("pend_cleared_lit", rs1_pending, 0);
    query_rs1 = 0;

    // Reset while a write sits in the output stage
    req0_valid = 1; req0_rd = 9; req0_data = 32'h99;
    tick(g);
    req0_valid = 0;
    rst = 1;
    #1 chk("midrst_regwrite_lit", RegWrite, 0);
    tick(g);
    rst = 0;
    #1 chk("midrst_after_lit", RegWrite, 0);
    tick(g);
    chk("midrst_rf9_lit", d_rf[9], 0);

    // Same destination from both requesters
    req0_valid = 1; req0_rd = 6; req0_data = 32'h1;
    tick(g);
    req0_valid = 0;
    req1_valid = 1; req1_rd = 6; req1_data = 32'h2;
    #1 chk("same_rd_first_data_lit", WriteData, 32'h1);
    chk("same_rd_first_rd_lit", Rd, 6);
    tick(g);
    req1_valid = 0;
    #1 chk("same_rd_second_data_lit", WriteData, 32'h2);
    chk("same_rd_second_we_lit", RegWrite, 1);
    tick(g);
    chk("same_rd_rf6_lit", d_rf[6], 32'h2);

    // Randomized traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!req0_valid && $urandom_range(0, 9) < 6) begin
        req0_valid = 1;
        req0_rd    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        req0_data  = $urandom;
      end
      if (!req1_valid && $urandom_range(0, 9) < 6) begin
        req1_valid = 1;
        req1_rd    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        req1_data  = $urandom;
      end
      query_rs1 = AW'($urandom_range(0, 8));
      query_rs2 = AW'($urandom);
      tick(g);
      if (g == 0) req0_valid = 0;
      if (g == 1) req1_valid = 0;
    end
    rst = 0; idle_inputs();
    tick(g); tick(g);
    #1;
    for (int i = 1; i < 32; i++) chk("regfile_contents", d_rf[i], m_rf[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
